// File: rtl/mpu_sched_pkg.sv
// Shared types for the MPU job scheduler: FSM state encodings and completion status codes.
package mpu_sched_pkg;

    localparam int EVT_W = 64;

    typedef enum logic [2:0] {
        MPU_SCHED_STATE_IDLE  = 3'd0,
        MPU_SCHED_STATE_RESET = 3'd1,
        MPU_SCHED_STATE_RUN   = 3'd2,
        MPU_SCHED_STATE_WAIT  = 3'd3,
        MPU_SCHED_STATE_DONE  = 3'd4
    } mpu_sched_state_e;

    typedef enum logic [1:0] {
        MPU_SCHED_STATUS_END     = 2'd0,
        MPU_SCHED_STATUS_ERROR   = 2'd1,
        MPU_SCHED_STATUS_ABORT   = 2'd2,
        MPU_SCHED_STATUS_TIMEOUT = 2'd3
    } mpu_sched_status_e;

endpackage

// File: rtl/mpu_rr_arbiter.sv
// Combinational round-robin pick: first requester found searching upward from last_i+1, wrapping.
module mpu_rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] last_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic                     any_o
);
    localparam int IW = $clog2(N_REQ);

    int pos;

    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        grant_o = '0;
        pos     = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            pos = int'(last_i) + k;
            if (pos >= N_REQ) pos = pos - N_REQ;
            if (req_i[pos[IW-1:0]]) begin
                grant_o              = '0;
                grant_o[pos[IW-1:0]] = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/mpu_sched.sv
// Round-robin scheduler sharing one MPU core among N_REQ requesters; all outputs registered.
// Optional RUN-cycle watchdog compiled in with MPU_SCHED_WATCHDOG_EN.
//   state | meaning
//   IDLE  | no job; arbitrate pending requests
//   RESET | mpu_rst held for one cycle, entry PC loaded
//   RUN   | mpu_en high, watching abort/error/irq/watchdog
//   WAIT  | core paused on user IRQ, event presented to owner
//   DONE  | one-cycle completion pulse to owner
module mpu_sched
    import mpu_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int PC_W        = 16,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*PC_W-1:0] req_pc,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ-1:0]      resume,
    input  logic [N_REQ-1:0]      abort,
    output logic [N_REQ-1:0]      evt_valid,
    output logic [EVT_W-1:0]      evt_data,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [1:0]            rsp_status,
    output logic                  mpu_rst,
    output logic                  mpu_en,
    output logic [PC_W-1:0]       mpu_pc,
    input  logic                  mpu_user_irq,
    input  logic [EVT_W-1:0]      mpu_user_data,
    input  logic                  mpu_error,
    output logic                  busy
);
    localparam int IW = $clog2(N_REQ);

    mpu_sched_state_e  state_q, state_d;
    mpu_sched_status_e status_d;
    logic [IW-1:0]     owner_q, owner_d, last_q, last_d, grant_idx;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [EVT_W-1:0]  evt_data_q, evt_data_d;
    logic [N_REQ-1:0]  grant, owner_oh;
    logic [N_REQ-1:0]  req_ready_q, req_ready_d, evt_valid_q, evt_valid_d, rsp_valid_q, rsp_valid_d;
    logic [1:0]        rsp_status_q, rsp_status_d;
    logic              grant_any, wdog_expired, owner_abort, owner_resume;
    logic              mpu_rst_q, mpu_rst_d, mpu_en_q, mpu_en_d, busy_q, busy_d;

    mpu_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_i   (req_valid),
        .last_i  (last_q),
        .grant_o (grant),
        .any_o   (grant_any)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) grant_idx = IW'(i);
        end
    end

    assign owner_abort  = abort[owner_q];
    assign owner_resume = resume[owner_q];

`ifdef MPU_SCHED_WATCHDOG_EN
    localparam int WDW = $clog2(WDOG_CYCLES + 1);
    logic [WDW-1:0] wdog_q, wdog_d;

    // Down-counter loaded as RUN is entered from RESET; frozen outside RUN so WAIT time is free.
    always_comb begin
        wdog_d = wdog_q;
        if (state_q == MPU_SCHED_STATE_RESET) begin
            wdog_d = WDW'(WDOG_CYCLES - 1);
        end else if (state_q == MPU_SCHED_STATE_RUN && wdog_q != '0) begin
            wdog_d = wdog_q - WDW'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) wdog_q <= '0;
        else         wdog_q <= wdog_d;
    end

    assign wdog_expired = (wdog_q == '0);
`else
    assign wdog_expired = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        pc_d       = pc_q;
        evt_data_d = evt_data_q;
        status_d   = MPU_SCHED_STATUS_END;
        case (state_q)
            MPU_SCHED_STATE_IDLE: begin
                if (grant_any) begin
                    owner_d = grant_idx;
                    pc_d    = req_pc[grant_idx*PC_W +: PC_W];
                    state_d = MPU_SCHED_STATE_RESET;
                end
            end
            MPU_SCHED_STATE_RESET: state_d = MPU_SCHED_STATE_RUN;
            MPU_SCHED_STATE_RUN: begin
                if (owner_abort) begin
                    state_d  = MPU_SCHED_STATE_DONE;
                    status_d = MPU_SCHED_STATUS_ABORT;
                end else if (mpu_error) begin
                    state_d  = MPU_SCHED_STATE_DONE;
                    status_d = MPU_SCHED_STATUS_ERROR;
                end else if (mpu_user_irq && mpu_user_data == '0) begin
                    state_d  = MPU_SCHED_STATE_DONE;
                    status_d = MPU_SCHED_STATUS_END;
                end else if (mpu_user_irq) begin
                    state_d    = MPU_SCHED_STATE_WAIT;
                    evt_data_d = mpu_user_data;
                end else if (wdog_expired) begin
                    state_d  = MPU_SCHED_STATE_DONE;
                    status_d = MPU_SCHED_STATUS_TIMEOUT;
                end
            end
            MPU_SCHED_STATE_WAIT: begin
                if (owner_abort) begin
                    state_d  = MPU_SCHED_STATE_DONE;
                    status_d = MPU_SCHED_STATUS_ABORT;
                end else if (owner_resume) begin
                    state_d = MPU_SCHED_STATE_RUN;
                end
            end
            MPU_SCHED_STATE_DONE: begin
                last_d  = owner_q;
                state_d = MPU_SCHED_STATE_IDLE;
            end
            default: state_d = MPU_SCHED_STATE_IDLE;
        endcase
        if (state_d != MPU_SCHED_STATE_WAIT) evt_data_d = '0;
    end

    // Outputs are decoded from the next state so they appear registered with the state change.
    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_d] = 1'b1;
        req_ready_d       = (state_q == MPU_SCHED_STATE_IDLE) ? grant : '0;
        mpu_rst_d         = (state_d == MPU_SCHED_STATE_RESET);
        mpu_en_d          = (state_d == MPU_SCHED_STATE_RUN);
        busy_d            = (state_d != MPU_SCHED_STATE_IDLE);
        evt_valid_d       = (state_d == MPU_SCHED_STATE_WAIT) ? owner_oh : '0;
        rsp_valid_d       = (state_d == MPU_SCHED_STATE_DONE) ? owner_oh : '0;
        rsp_status_d      = (state_d == MPU_SCHED_STATE_DONE) ? status_d : MPU_SCHED_STATUS_END;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= MPU_SCHED_STATE_IDLE;
            owner_q      <= '0;
            last_q       <= IW'(N_REQ - 1);
            pc_q         <= '0;
            evt_data_q   <= '0;
            req_ready_q  <= '0;
            evt_valid_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_status_q <= '0;
            mpu_rst_q    <= 1'b0;
            mpu_en_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            pc_q         <= pc_d;
            evt_data_q   <= evt_data_d;
            req_ready_q  <= req_ready_d;
            evt_valid_q  <= evt_valid_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            mpu_rst_q    <= mpu_rst_d;
            mpu_en_q     <= mpu_en_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign evt_valid  = evt_valid_q;
    assign evt_data   = evt_data_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_status = rsp_status_q;
    assign mpu_rst    = mpu_rst_q;
    assign mpu_en     = mpu_en_q;
    assign mpu_pc     = pc_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mpu_sched.sv
// Self-checking bench for mpu_sched: job-level reference model compared every cycle, plus directed literal checks.
module tb_mpu_sched;
    localparam int N  = 4;
    localparam int PW = 16;
    localparam int WD = 20;
`ifdef MPU_SCHED_WATCHDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    localparam logic [1:0] S_END = 2'd0, S_ERR = 2'd1, S_ABORT = 2'd2, S_TOUT = 2'd3;

    logic            clk = 1'b0;
    logic            sys_rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*PW-1:0] req_pc = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resume = '0;
    logic [N-1:0]    abort = '0;
    logic [N-1:0]    evt_valid;
    logic [63:0]     evt_data;
    logic [N-1:0]    rsp_valid;
    logic [1:0]      rsp_status;
    logic            mpu_rst, mpu_en, busy;
    logic [PW-1:0]   mpu_pc;
    logic            mpu_user_irq = 1'b0;
    logic [63:0]     mpu_user_data = '0;
    logic            mpu_error = 1'b0;

    always #5 clk = ~clk;

    mpu_sched #(.N_REQ(N), .PC_W(PW), .WDOG_CYCLES(WD)) dut (
        .sys_clk(clk), .sys_rst(sys_rst),
        .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
        .resume(resume), .abort(abort),
        .evt_valid(evt_valid), .evt_data(evt_data),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status),
        .mpu_rst(mpu_rst), .mpu_en(mpu_en), .mpu_pc(mpu_pc),
        .mpu_user_irq(mpu_user_irq), .mpu_user_data(mpu_user_data), .mpu_error(mpu_error),
        .busy(busy)
    );

    int tests = 0;
    int fails = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: tracks the current job (who owns the core and which phase of its life it is in).
    localparam int J_NONE = 0, J_GRANTED = 1, J_RUNNING = 2, J_PAUSED = 3, J_REPORTING = 4;
    int            job = J_NONE;
    int            m_owner = 0;
    int            m_last = N - 1;
    int            m_runs = 0;
    int            pick;
    logic [N-1:0]  e_req_ready = '0, e_evt_valid = '0, e_rsp_valid = '0;
    logic [1:0]    e_status = '0;
    logic          e_rst = 1'b0, e_en = 1'b0, e_busy = 1'b0;
    logic [PW-1:0] e_pc = '0;
    logic [63:0]   e_evt_data = '0;
    int            done_owner[$];
    int            done_status[$];

    task automatic model_finish(input logic [1:0] s);
        e_en                 = 1'b0;
        e_evt_valid          = '0;
        e_evt_data           = '0;
        e_rsp_valid[m_owner] = 1'b1;
        e_status             = s;
        done_owner.push_back(m_owner);
        done_status.push_back(int'(s));
        job = J_REPORTING;
    endtask

    always @(posedge clk) begin
        e_req_ready = '0;
        e_rsp_valid = '0;
        e_status    = '0;
        e_rst       = 1'b0;
        if (sys_rst) begin
            job = J_NONE; m_last = N - 1;
            e_en = 1'b0; e_evt_valid = '0; e_evt_data = '0; e_pc = '0; e_busy = 1'b0;
        end else begin
            case (job)
                J_NONE: begin
                    pick = -1;
                    for (int d = 1; d <= N; d++) begin
                        if (pick < 0 && req_valid[(m_last + d) % N]) pick = (m_last + d) % N;
                    end
                    if (pick >= 0) begin
                        m_owner = pick;
                        e_pc = req_pc[pick*PW +: PW];
                        e_req_ready[pick] = 1'b1;
                        e_rst = 1'b1;
                        e_busy = 1'b1;
                        job = J_GRANTED;
                    end
                end
                J_GRANTED: begin
                    e_en = 1'b1; m_runs = 0; job = J_RUNNING;
                end
                J_RUNNING: begin
                    m_runs++;
                    if (abort[m_owner]) model_finish(S_ABORT);
                    else if (mpu_error) model_finish(S_ERR);
                    else if (mpu_user_irq && mpu_user_data == 64'd0) model_finish(S_END);
                    else if (mpu_user_irq) begin
                        e_en = 1'b0;
                        e_evt_valid[m_owner] = 1'b1;
                        e_evt_data = mpu_user_data;
                        job = J_PAUSED;
                    end else if (WDOG_ON && m_runs == WD) model_finish(S_TOUT);
                end
                J_PAUSED: begin
                    if (abort[m_owner]) model_finish(S_ABORT);
                    else if (resume[m_owner]) begin
                        e_evt_valid = '0; e_evt_data = '0; e_en = 1'b1; job = J_RUNNING;
                    end
                end
                default: begin
                    m_last = m_owner; e_busy = 1'b0; job = J_NONE;
                end
            endcase
        end
    end

    int mon_grants[$];

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("req_ready", 64'(req_ready), 64'(e_req_ready));
            chk("evt_valid", 64'(evt_valid), 64'(e_evt_valid));
            chk("evt_data", evt_data, e_evt_data);
            chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp_valid));
            chk("rsp_status", 64'(rsp_status), 64'(e_status));
            chk("mpu_rst", 64'(mpu_rst), 64'(e_rst));
            chk("mpu_en", 64'(mpu_en), 64'(e_en));
            chk("mpu_pc", 64'(mpu_pc), 64'(e_pc));
            chk("busy", 64'(busy), 64'(e_busy));
            for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) mon_grants.push_back(i);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic request(input int p, input logic [PW-1:0] pc);
        int n;
        req_valid[p] = 1'b1;
        req_pc[p*PW +: PW] = pc;
        n = 0;
        do begin tick(); n++; end while (req_ready[p] !== 1'b1 && n < 40);
        chk("grant_seen", 64'(req_ready[p]), 64'd1);
        req_valid[p] = 1'b0;
    endtask

    task automatic wait_en(output int n);
        n = 0;
        while (mpu_en !== 1'b1 && n < 20) begin tick(); n++; end
        chk("mpu_en_seen", 64'(mpu_en), 64'd1);
    endtask

    task automatic irq_pulse(input logic [63:0] data);
        mpu_user_irq = 1'b1;
        mpu_user_data = data;
        tick();
        mpu_user_irq = 1'b0;
        mpu_user_data = '0;
    endtask

    initial begin
        int n;
        tick(); tick();
        sys_rst = 1'b0;
        cmp_on = 1'b1;
        chk("reset_outputs", 64'({req_ready, evt_valid, rsp_valid, rsp_status, mpu_rst, mpu_en, mpu_pc, busy}), 64'd0);
        chk("reset_evt_data", evt_data, 64'd0);

        // Single job on port 2, END after 10 RUN cycles.
        req_valid[2] = 1'b1;
        req_pc[2*PW +: PW] = 16'h0100;
        tick();
        chk("t1_ready_T1", 64'(req_ready), 64'h4);
        chk("t1_rst_T1", 64'(mpu_rst), 64'd1);
        chk("t1_en_T1", 64'(mpu_en), 64'd0);
        req_valid[2] = 1'b0;
        tick();
        chk("t1_en_T2", 64'(mpu_en), 64'd1);
        chk("t1_pc", 64'(mpu_pc), 64'h0100);
        repeat (9) tick();
        chk("t1_still_running", 64'(mpu_en), 64'd1);
        irq_pulse(64'd0);
        chk("t1_rsp_valid", 64'(rsp_valid), 64'h4);
        chk("t1_rsp_status", 64'(rsp_status), 64'(S_END));
        chk("t1_en_low", 64'(mpu_en), 64'd0);
        chk("t1_model_owner", 64'(done_owner[$]), 64'd2);
        tick();
        chk("t1_idle", 64'(busy), 64'd0);

        // Round robin with every port requesting continuously.
        sys_rst = 1'b1; tick(); sys_rst = 1'b0;
        for (int i = 0; i < N; i++) req_pc[i*PW +: PW] = 16'(16'h1000 + i);
        mon_grants.delete();
        req_valid = '1;
        for (int j = 0; j < 5; j++) begin
            wait_en(n);
            if (j > 0) chk("rr_regrant_latency", 64'(n), 64'd3);
            tick(); tick();
            if (j == 4) req_valid = '0;
            irq_pulse(64'd0);
        end
        req_valid = '0;
        tick(); tick();
        chk("rr_count", 64'(mon_grants.size()), 64'd5);
        for (int j = 0; j < 5 && j < mon_grants.size(); j++) chk("rr_order", 64'(mon_grants[j]), 64'(j % N));

        // User IRQ wait with data, ignored error/irq in WAIT, resume, then END.
        request(1, 16'h2000);
        wait_en(n);
        tick(); tick();
        irq_pulse(64'hDEADBEEF_00000001);
        chk("w_evt_valid", 64'(evt_valid), 64'h2);
        chk("w_evt_data", evt_data, 64'hDEADBEEF_00000001);
        chk("w_en_low", 64'(mpu_en), 64'd0);
        mpu_error = 1'b1; mpu_user_irq = 1'b1;
        tick();
        mpu_error = 1'b0; mpu_user_irq = 1'b0;
        chk("w_ignore_events", 64'(evt_valid), 64'h2);
        chk("w_no_rsp", 64'(rsp_valid), 64'd0);
        tick();
        resume[1] = 1'b1;
        tick();
        resume[1] = 1'b0;
        chk("w_resume_en", 64'(mpu_en), 64'd1);
        chk("w_resume_evt", 64'(evt_valid), 64'd0);
        chk("w_resume_data", evt_data, 64'd0);
        tick();
        irq_pulse(64'd0);
        chk("w_rsp", 64'(rsp_valid), 64'h2);
        chk("w_status", 64'(rsp_status), 64'(S_END));

        // Abort beats error in the same RUN cycle.
        request(0, 16'h3000);
        wait_en(n);
        tick();
        mpu_error = 1'b1; abort[0] = 1'b1;
        tick();
        mpu_error = 1'b0; abort[0] = 1'b0;
        chk("p_rsp", 64'(rsp_valid), 64'h1);
        chk("p_status", 64'(rsp_status), 64'(S_ABORT));

        // Plain error completion.
        request(1, 16'h3100);
        wait_en(n);
        mpu_error = 1'b1;
        tick();
        mpu_error = 1'b0;
        chk("e_status", 64'(rsp_status), 64'(S_ERR));

        // Abort beats resume in WAIT.
        request(3, 16'h4000);
        wait_en(n);
        irq_pulse(64'h5);
        chk("ar_evt_valid", 64'(evt_valid), 64'h8);
        abort[3] = 1'b1; resume[3] = 1'b1;
        tick();
        abort[3] = 1'b0; resume[3] = 1'b0;
        chk("ar_rsp", 64'(rsp_valid), 64'h8);
        chk("ar_status", 64'(rsp_status), 64'(S_ABORT));
        chk("ar_evt_cleared", 64'(evt_valid), 64'd0);

        // Non-owner abort/resume ignored; non-owner request stays pending.
        request(2, 16'h5000);
        wait_en(n);
        abort = 4'b1011; resume = 4'b1011;
        req_valid[0] = 1'b1; req_pc[0 +: PW] = 16'h5100;
        repeat (3) tick();
        chk("na_running", 64'(mpu_en), 64'd1);
        chk("na_no_rsp", 64'(rsp_valid), 64'd0);
        abort = '0; resume = '0;
        irq_pulse(64'd0);
        chk("na_rsp", 64'(rsp_valid), 64'h4);
        chk("na_status", 64'(rsp_status), 64'(S_END));
        tick(); tick();
        chk("na_pending_grant", 64'(req_ready), 64'h1);
        chk("na_pending_pc", 64'(mpu_pc), 64'h5100);
        req_valid[0] = 1'b0;
        wait_en(n);
        irq_pulse(64'd0);

        // Reset mid-RUN, then ports 0 and 3 together.
        request(1, 16'h6000);
        wait_en(n);
        tick(); tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("mr_outputs", 64'({req_ready, evt_valid, rsp_valid, rsp_status, mpu_rst, mpu_en, mpu_pc, busy}), 64'd0);
        repeat (3) begin tick(); chk("mr_no_rsp", 64'(rsp_valid), 64'd0); end
        req_valid = 4'b1001;
        tick();
        chk("mr_grant0", 64'(req_ready), 64'h1);
        req_valid = '0;
        wait_en(n);
        irq_pulse(64'd0);
        tick();

`ifdef MPU_SCHED_WATCHDOG_EN
        request(0, 16'h7000);
        wait_en(n);
        n = 0;
        while (rsp_valid[0] !== 1'b1 && n < 60) begin tick(); n++; end
        chk("wd_plain_cycles", 64'(n), 64'd20);
        chk("wd_plain_status", 64'(rsp_status), 64'(S_TOUT));
        request(1, 16'h7100);
        wait_en(n);
        irq_pulse(64'h1);
        tick(); tick(); tick();
        resume[1] = 1'b1;
        tick();
        resume[1] = 1'b0;
        n = 5;
        while (rsp_valid[1] !== 1'b1 && n < 80) begin tick(); n++; end
        chk("wd_wait_cycles", 64'(n), 64'd24);
        chk("wd_wait_status", 64'(rsp_status), 64'(S_TOUT));
`endif

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not reach its end, tests=%0d failed=%0d", tests, fails + 1);
        $fatal(1, "timeout");
    end

endmodule
